fu_arbiter: RTL and testbench

Two-requester round-robin arbiter and issue sequencer for the shared 16-bit function unit (FU). The main execute path and the secondary requester (multiply/shift micro-sequencer or debug port) each present operands and an `fs_t` function select. The arbiter grants one request per cycle and registers the operands into a single issue stage that drives the combinational FU. It then captures `f_out`/`nz_out` into a one-deep response buffer per requester, with valid/ready handshakes on both sides.

---
 rtl/fu_arbiter.sv | 155 +++++++++++++++
 tb/tb_fu_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_arbiter.sv
// fu_arbiter: two-requester round-robin arbiter feeding one registered issue stage of the shared 16-bit FU.
// Latency: request accepted at edge N drives the FU during N..N+1; response valid after edge N+1.
// Backpressure: a requester is not ready while its own op is in flight or its held response is not being consumed.

package fu_arbiter_pkg;
  // FU function select; the FU owns all arithmetic, the arbiter only forwards it.
  typedef enum logic [3:0] {
    FMOVA = 4'd0,
    FMOVB = 4'd1,
    FADD  = 4'd2,
    FSUB  = 4'd3,
    FMUL  = 4'd4,
    FINC  = 4'd5,
    FDEC  = 4'd6,
    FNOT  = 4'd7,
    FAND  = 4'd8,
    FOR   = 4'd9,
    FXOR  = 4'd10,
    FSHL  = 4'd11,
    FSHR  = 4'd12
  } fs_t;
endpackage

module fu_arbiter
  import fu_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][15:0] req_a,
  input  logic [1:0][15:0] req_b,
  input  fs_t  [1:0]       req_fs,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [1:0][15:0] rsp_f,
  output logic [1:0][1:0]  rsp_nz,
  output logic [15:0]      fu_a,
  output logic [15:0]      fu_b,
  output fs_t              fu_fs,
  input  logic [15:0]      fu_f,
  input  logic [1:0]       fu_nz
);

  // Issue stage. The control "state" is implicit in these registers:
  // idle when nothing is issued or buffered, issue while op_valid_q,
  // hold while only responses are waiting.
  logic        op_valid_q, op_valid_d;
  logic        op_id_q, op_id_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  fs_t         op_fs_q, op_fs_d;
  logic        last_q, last_d;

  // One-deep response buffer per requester.
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0][15:0] rsp_f_q, rsp_f_d;
  logic [1:0][1:0]  rsp_nz_q, rsp_nz_d;

  logic [1:0] inflight;
  logic [1:0] elig;
  logic [1:0] cand;
  logic       grant;
  logic [1:0] accept;

  // Eligibility and round-robin grant. With no competing candidate the
  // grant parks on the requester that did not win last, so ready is
  // offered there while idle. Ready of the non-preferred requester can
  // rise when it alone presents valid, so requesters must not gate valid
  // on ready.
  always_comb begin
    inflight          = 2'b00;
    inflight[op_id_q] = op_valid_q;
    elig              = ~inflight & (~rsp_valid_q | rsp_ready);
    cand              = req_valid & elig;
    case (cand)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_q;
    endcase
    req_ready = {elig[1] & grant, elig[0] & ~grant};
    accept    = req_valid & req_ready;
  end

  // Issue register: load on accept; otherwise drop valid but keep the
  // operands so the FU inputs stay quiet while idle.
  always_comb begin
    op_valid_d = |accept;
    op_id_d    = op_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_fs_d    = op_fs_q;
    last_d     = last_q;
    if (|accept) begin
      op_id_d = grant;
      op_a_d  = req_a[grant];
      op_b_d  = req_b[grant];
      op_fs_d = req_fs[grant];
      last_d  = grant;
    end
  end

  // Response buffers: pop on handshake, then a completion for the same
  // requester overrides the pop in the same edge.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_f_d     = rsp_f_q;
    rsp_nz_d    = rsp_nz_q;
    if (op_valid_q) begin
      rsp_valid_d[op_id_q] = 1'b1;
      rsp_f_d[op_id_q]     = fu_f;
      rsp_nz_d[op_id_q]    = fu_nz;
    end
  end

  // Issue stage and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_id_q    <= 1'b0;
      op_a_q     <= 16'h0000;
      op_b_q     <= 16'h0000;
      op_fs_q    <= FMOVA;
      last_q     <= 1'b1;
    end else begin
      op_valid_q <= op_valid_d;
      op_id_q    <= op_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_fs_q    <= op_fs_d;
      last_q     <= last_d;
    end
  end

  // Response buffer registers; reset discards anything buffered or in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_f_q     <= '0;
      rsp_nz_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      rsp_nz_q    <= rsp_nz_d;
    end
  end

  assign fu_a      = op_a_q;
  assign fu_b      = op_b_q;
  assign fu_fs     = op_fs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_nz    = rsp_nz_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// tb_fu_arbiter: directed scenarios plus random traffic against a transaction-level model.
// The model computes each result from the request operands at accept time and tracks
// what every requester should see; a negedge process compares the DUT to it every cycle.
module tb_fu_arbiter;
  import fu_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][15:0] req_a, req_b, rsp_f;
  fs_t  [1:0]       req_fs;
  logic [1:0][1:0]  rsp_nz;
  logic [15:0]      fu_a, fu_b, fu_f;
  fs_t              fu_fs;
  logic [1:0]       fu_nz;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit          m_bv [2];
  logic [15:0] m_bf [2];
  logic [1:0]  m_bn [2];
  bit          m_fly;
  int          m_fid;
  logic [15:0] m_ff;
  logic [1:0]  m_fn;
  int          m_last;
  logic [15:0] m_ha, m_hb;
  fs_t         m_hfs;
  int          dut_log [$];

  fu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fs(req_fs),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_nz(rsp_nz),
    .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs),
    .fu_f(fu_f), .fu_nz(fu_nz)
  );

  always #5 clk = ~clk;

  // Reference FU: signed saturating arithmetic, plain logic ops, shifts on B.
  function automatic logic [17:0] fu_ref(input logic [15:0] a, input logic [15:0] b, input fs_t fs);
    int sa, sb, r;
    logic [15:0] f;
    bit arith;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    arith = 1'b1;
    f = 16'h0000;
    case (fs)
      FADD:    r = sa + sb;
      FSUB:    r = sa - sb;
      FMUL:    r = sa * sb;
      FINC:    r = sa + 1;
      FDEC:    r = sa - 1;
      default: arith = 1'b0;
    endcase
    if (arith) begin
      if (r > 32767)       f = 16'h7FFF;
      else if (r < -32768) f = 16'h8000;
      else                 f = r[15:0];
    end else begin
      case (fs)
        FMOVB:   f = b;
        FNOT:    f = ~a;
        FAND:    f = a & b;
        FOR:     f = a | b;
        FXOR:    f = a ^ b;
        FSHL:    f = {b[14:0], 1'b0};
        FSHR:    f = {1'b0, b[15:1]};
        default: f = a;
      endcase
    end
    return {f[15], (f == 16'h0000), f};
  endfunction

  assign {fu_nz, fu_f} = fu_ref(fu_a, fu_b, fu_fs);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bv[i] = 1'b0;
      m_bf[i] = 16'h0000;
      m_bn[i] = 2'b00;
    end
    m_fly  = 1'b0;
    m_fid  = 0;
    m_ff   = 16'h0000;
    m_fn   = 2'b00;
    m_last = 1;
    m_ha   = 16'h0000;
    m_hb   = 16'h0000;
    m_hfs  = FMOVA;
  endtask

  // Which requesters should see ready, from the arbitration rules.
  function automatic logic [1:0] exp_ready();
    bit el [2];
    bit c [2];
    int g;
    for (int i = 0; i < 2; i++) begin
      el[i] = !(m_fly && m_fid == i) && (!m_bv[i] || rsp_ready[i]);
      c[i]  = req_valid[i] && el[i];
    end
    if (c[0] && c[1]) g = 1 - m_last;
    else if (c[0])    g = 0;
    else if (c[1])    g = 1;
    else              g = 1 - m_last;
    return {el[1] && (g == 1), el[0] && (g == 0)};
  endfunction

  // Advance the model over one rising edge using the inputs present at it.
  task automatic model_step();
    logic [1:0]  er;
    logic [17:0] r;
    int acc;
    if (!rst_n) return;
    er = exp_ready();
    acc = -1;
    for (int i = 0; i < 2; i++) if (req_valid[i] && er[i]) acc = i;
    for (int i = 0; i < 2; i++) if (m_bv[i] && rsp_ready[i]) m_bv[i] = 1'b0;
    if (m_fly) begin
      m_bv[m_fid] = 1'b1;
      m_bf[m_fid] = m_ff;
      m_bn[m_fid] = m_fn;
    end
    m_fly = (acc >= 0);
    if (acc >= 0) begin
      r      = fu_ref(req_a[acc], req_b[acc], req_fs[acc]);
      m_fid  = acc;
      m_fn   = r[17:16];
      m_ff   = r[15:0];
      m_last = acc;
      m_ha   = req_a[acc];
      m_hb   = req_b[acc];
      m_hfs  = req_fs[acc];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input fs_t fs);
    req_a[i]     = a;
    req_b[i]     = b;
    req_fs[i]    = fs;
    req_valid[i] = 1'b1;
  endtask

  function automatic fs_t rand_fs();
    return fs_t'(4'($urandom_range(0, 12)));
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] er;
    er = exp_ready();
    chk("req_ready", 16'(req_ready), 16'(er));
    chk("rsp_valid", 16'(rsp_valid), {14'd0, m_bv[1], m_bv[0]});
    for (int i = 0; i < 2; i++) begin
      if (m_bv[i]) begin
        chk("rsp_f", rsp_f[i], m_bf[i]);
        chk("rsp_nz", 16'(rsp_nz[i]), 16'(m_bn[i]));
      end
    end
    chk("fu_a", fu_a, m_ha);
    chk("fu_b", fu_b, m_hb);
    chk("fu_fs", 16'(fu_fs), 16'(m_hfs));
    if (rst_n) begin
      for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) dut_log.push_back(i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_fs[0] = FMOVA;
    req_fs[1] = FMOVA;
    model_reset();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 16'(req_ready), 16'h0001);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
    chk("rst_fu_a", fu_a, 16'h0000);
    chk("rst_fu_fs", 16'(fu_fs), 16'(FMOVA));
    tick();

    // Single FADD from requester 0, two-edge latency
    set_req(0, 16'h0003, 16'h0004, FADD);
    @(negedge clk);
    chk("t1_ready0", 16'(req_ready[0]), 16'h0001);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("t1_rsp_valid0", 16'(rsp_valid[0]), 16'h0001);
    chk("t1_rsp_f0", rsp_f[0], 16'h0007);
    chk("t1_rsp_nz0", 16'(rsp_nz[0]), 16'h0000);
    tick();
    rsp_ready = 2'b11;
    tick();

    // Both valid from reset: requester 0 first, then 1
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 16'h0005, 16'h0005, FSUB);
    set_req(1, 16'h4000, 16'h0004, FMUL);
    @(negedge clk);
    chk("t2_ready_first", 16'(req_ready), 16'h0001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t2_ready_second", 16'(req_ready), 16'h0002);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid0", 16'(rsp_valid[0]), 16'h0001);
    chk("t2_rsp_f0", rsp_f[0], 16'h0000);
    chk("t2_rsp_nz0", 16'(rsp_nz[0]), 16'h0001);
    tick();
    @(negedge clk);
    chk("t2_rsp_valid1", 16'(rsp_valid[1]), 16'h0001);
    chk("t2_rsp_f1", rsp_f[1], 16'h7FFF);
    chk("t2_rsp_nz1", 16'(rsp_nz[1]), 16'h0000);
    tick();

    // Fairness: both continuously valid, grants must alternate every cycle
    do_reset();
    rsp_ready = 2'b11;
    dut_log.delete();
    for (int k = 0; k < 8; k++) begin
      set_req(0, 16'($urandom), 16'($urandom), rand_fs());
      set_req(1, 16'($urandom), 16'($urandom), rand_fs());
      tick();
    end
    req_valid = 2'b00;
    chk("t3_grant_count", 16'(dut_log.size()), 16'd8);
    for (int k = 0; k < 8 && k < dut_log.size(); k++)
      chk("t3_grant_order", 16'(dut_log[k]), 16'(k % 2));
    repeat (3) tick();

    // Backpressure on requester 1 while requester 0 streams FINC
    do_reset();
    rsp_ready = 2'b01;
    set_req(1, 16'h0000, 16'($urandom), FNOT);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 16'($urandom_range(0, 1000)), 16'($urandom), FINC);
    tick();
    dut_log.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_ready1_blocked", 16'(req_ready[1]), 16'h0000);
      chk("t4_rsp_valid1", 16'(rsp_valid[1]), 16'h0001);
      chk("t4_rsp_f1", rsp_f[1], 16'hFFFF);
      chk("t4_rsp_nz1", 16'(rsp_nz[1]), 16'h0002);
      tick();
      req_a[0] = 16'($urandom_range(0, 1000));
      set_req(1, 16'($urandom), 16'($urandom), FMOVA);
    end
    chk("t4_req0_accepts", 16'(dut_log.size()), 16'd2);
    for (int k = 0; k < dut_log.size(); k++) chk("t4_req0_only", 16'(dut_log[k]), 16'd0);
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("t4_ready1_release", 16'(req_ready[1]), 16'h0001);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    // Reset while an FDEC is in flight: the result must never appear
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 16'h0000, 16'($urandom), FDEC);
    tick();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    model_reset();
    @(negedge clk);
    chk("t5_rsp_in_reset", 16'(rsp_valid), 16'h0000);
    chk("t5_ready_in_reset", 16'(req_ready), 16'h0001);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", 16'(req_ready), 16'h0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("t5_no_rsp", 16'(rsp_valid), 16'h0000);
    end
    tick();

    // FSHL then idle: FU inputs must hold while requests are absent
    rsp_ready = 2'b00;
    set_req(0, 16'h1234, 16'h8001, FSHL);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("t6_rsp_f0", rsp_f[0], 16'h0002);
    chk("t6_rsp_nz0", 16'(rsp_nz[0]), 16'h0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        req_a[i]  = 16'($urandom);
        req_b[i]  = 16'($urandom);
        req_fs[i] = rand_fs();
      end
      @(negedge clk);
      chk("t6_fu_a_hold", fu_a, 16'h1234);
      chk("t6_fu_b_hold", fu_b, 16'h8001);
      chk("t6_fu_fs_hold", 16'(fu_fs), 16'(FSHL));
    end
    tick();

    // Random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      for (int i = 0; i < 2; i++) begin
        req_a[i]  = 16'($urandom);
        req_b[i]  = 16'($urandom);
        req_fs[i] = rand_fs();
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
